// File: rtl/lcd_pkg.sv
// Shared FSM state type and HD44780 constants for the LCD bus scheduler.
// The init ROM is only consumed when LCD_INIT_SEQ_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PWRUP = 3'd1,
    ST_SETUP = 3'd2,
    ST_PULSE = 3'd3,
    ST_WAIT  = 3'd4
  } lcd_state_e;

  localparam logic [7:0] CMD_CLR    = 8'h01;
  localparam logic [7:0] CMD_HOME   = 8'h02;
  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;

  localparam int         INIT_LEN  = 4;
  localparam logic [1:0] INIT_LAST = 2'(INIT_LEN - 32'sd1);

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = FUNC_SET;
      2'd1:    b = DISP_ON;
      2'd2:    b = CMD_CLR;
      2'd3:    b = ENTRY_MODE;
      default: b = FUNC_SET;
    endcase
    return b;
  endfunction

  // Clear and home need the long post-write wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == CMD_CLR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_bus_sched_if.sv
// Requester-side handshake and LCD pin bundle for lcd_bus_sched.
interface lcd_bus_sched_if;
  logic [1:0] req;
  logic [1:0] req_rs;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] gnt;
  logic       busy;
  logic [7:0] lcd_data;
  logic       en;
  logic       rs;
  logic       wr;

  modport master (
    output req, req_rs, req_data0, req_data1,
    input  gnt, busy, lcd_data, en, rs, wr
  );

  modport slave (
    input  req, req_rs, req_data0, req_data1,
    output gnt, busy, lcd_data, en, rs, wr
  );
endinterface

// File: rtl/lcd_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant from req, pointer moves only on advance.
module lcd_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_r;

  // Contention goes to the requester that did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_r ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset marks requester 1 as last winner so requester 0 is favoured first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (advance && (grant != 2'b00)) begin
      last_r <= grant[1];
    end else begin
      last_r <= last_r;
    end
  end
endmodule

// File: rtl/lcd_bus_sched.sv
// HD44780 bus scheduler: arbitrates two byte writers, times en pulse and busy wait.
// Optional power-up init sequence enabled by defining LCD_INIT_SEQ_EN.
module lcd_bus_sched
  import lcd_pkg::*;
#(
  parameter int CNT_W   = 20,
  parameter int T_SETUP = 2,
  parameter int T_EN    = 12,
  parameter int T_CMD   = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_PWRUP = 750000
) (
  input logic            clk,
  input logic            rst,
  lcd_bus_sched_if.slave bus
);
  localparam longint CNT_MAX = (64'sd1 <<< CNT_W) - 64'sd1;

  if ((T_SETUP < 32'sd1) || (T_EN < 32'sd1) || (T_CMD < 32'sd1) || (T_CLR < 32'sd1) ||
      (T_PWRUP < 32'sd1) || (longint'(T_SETUP) - 64'sd1 > CNT_MAX) ||
      (longint'(T_EN) - 64'sd1 > CNT_MAX) || (longint'(T_CMD) - 64'sd1 > CNT_MAX) ||
      (longint'(T_CLR) - 64'sd1 > CNT_MAX) || (longint'(T_PWRUP) - 64'sd1 > CNT_MAX))
  begin : g_param_check
    $error("lcd_bus_sched: timing parameter below 1 or too wide for CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 32'sd1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(T_EN - 32'sd1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(T_CMD - 32'sd1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(T_CLR - 32'sd1);
`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e       RST_STATE = ST_PWRUP;
  localparam logic [CNT_W-1:0] RST_CNT   = CNT_W'(T_PWRUP - 32'sd1);
  localparam logic             RST_BUSY  = 1'b1;
`else
  localparam lcd_state_e       RST_STATE = ST_IDLE;
  localparam logic [CNT_W-1:0] RST_CNT   = {CNT_W{1'b0}};
  localparam logic             RST_BUSY  = 1'b0;
`endif

  lcd_state_e       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       data_r, data_s;
  logic             rs_r, rs_s;
  logic             en_r, en_s;
  logic             busy_r, busy_s;
  logic [1:0]       gnt_r, gnt_s;
  logic [1:0]       arb_gnt_s;
  logic             adv_s;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]       idx_r, idx_s;
  logic             init_r, init_s;
`endif

  lcd_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req),
    .advance(adv_s),
    .grant  (arb_gnt_s)
  );

  // Next state, shared down-counter and bus register values.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    data_s  = data_r;
    rs_s    = rs_r;
    en_s    = 1'b0;
    gnt_s   = 2'b00;
    adv_s   = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    idx_s   = idx_r;
    init_s  = init_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          adv_s   = 1'b1;
          gnt_s   = arb_gnt_s;
          data_s  = arb_gnt_s[1] ? bus.req_data1 : bus.req_data0;
          rs_s    = arb_gnt_s[1] ? bus.req_rs[1] : bus.req_rs[0];
          cnt_s   = SETUP_LD;
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_PULSE;
          cnt_s   = EN_LD;
          en_s    = 1'b1;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_WAIT;
          cnt_s   = is_long_cmd(rs_r, data_r) ? CLR_LD : CMD_LD;
        end else begin
          en_s    = 1'b1;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
`ifdef LCD_INIT_SEQ_EN
          if (init_r && (idx_r != INIT_LAST)) begin
            idx_s   = idx_r + 2'd1;
            data_s  = init_byte(idx_r + 2'd1);
            rs_s    = 1'b0;
            cnt_s   = SETUP_LD;
            state_s = ST_SETUP;
          end else begin
            init_s  = 1'b0;
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      ST_PWRUP: begin
`ifdef LCD_INIT_SEQ_EN
        if (cnt_r == CNT_ZERO) begin
          idx_s   = 2'd0;
          data_s  = init_byte(2'd0);
          rs_s    = 1'b0;
          cnt_s   = SETUP_LD;
          state_s = ST_SETUP;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
        end
`else
        state_s = ST_IDLE;
`endif
      end
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RST_STATE;
      cnt_r   <= RST_CNT;
      data_r  <= 8'h00;
      rs_r    <= 1'b0;
      en_r    <= 1'b0;
      gnt_r   <= 2'b00;
      busy_r  <= RST_BUSY;
`ifdef LCD_INIT_SEQ_EN
      idx_r   <= 2'd0;
      init_r  <= 1'b1;
`endif
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      data_r  <= data_s;
      rs_r    <= rs_s;
      en_r    <= en_s;
      gnt_r   <= gnt_s;
      busy_r  <= busy_s;
`ifdef LCD_INIT_SEQ_EN
      idx_r   <= idx_s;
      init_r  <= init_s;
`endif
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.busy     = busy_r;
  assign bus.lcd_data = data_r;
  assign bus.en       = en_r;
  assign bus.rs       = rs_r;
  assign bus.wr       = 1'b0;
endmodule

// File: tb/tb_lcd_bus_sched.sv
// Self-checking bench for lcd_bus_sched: directed scenarios plus randomized traffic
// checked against a transaction-timeline reference model.
module tb_lcd_bus_sched;
  localparam int CNT_W = 20, T_SETUP = 1, T_EN = 2, T_CMD = 4, T_CLR = 8, T_PWRUP = 10;
`ifdef LCD_INIT_SEQ_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  logic clk, rst;
  int   total, bad, cyc;
  int   init_list[$];

  lcd_bus_sched_if bus ();

  lcd_bus_sched #(.CNT_W(CNT_W), .T_SETUP(T_SETUP), .T_EN(T_EN), .T_CMD(T_CMD),
                  .T_CLR(T_CLR), .T_PWRUP(T_PWRUP))
    dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each transaction is a timeline of T_SETUP + T_EN + wait busy cycles.
  bit         m_active, m_pwr;
  int         m_pos, m_len, m_last;
  logic [7:0] m_data;
  logic       m_rs;
  logic [1:0] m_gnt;
  int         m_initq[$];

  function automatic int wait_of(input logic rs_v, input logic [7:0] d);
    return (rs_v == 1'b0 && (d == 8'h01 || d == 8'h02)) ? T_CLR : T_CMD;
  endfunction

  function automatic int init_total();
    int s = 0;
    if (init_list.size() > 0) s = T_PWRUP;
    foreach (init_list[i]) s += T_SETUP + T_EN + wait_of(1'b0, 8'(init_list[i]));
    return s;
  endfunction

  function automatic void model_start_init();
    m_data = 8'(m_initq.pop_front());
    m_rs = 1'b0; m_pwr = 1'b0; m_pos = 0; m_active = 1'b1;
    m_len = T_SETUP + T_EN + wait_of(1'b0, m_data);
  endfunction

  function automatic void model_reset();
    m_active = 1'b0; m_pwr = 1'b0; m_pos = 0; m_len = 0; m_last = 1;
    m_data = 8'h00; m_rs = 1'b0; m_gnt = 2'b00;
    m_initq = init_list;
    if (m_initq.size() > 0) begin
      m_active = 1'b1; m_pwr = 1'b1; m_len = T_PWRUP;
    end
  endfunction

  function automatic void model_step(input logic r, input logic [1:0] req, input logic [1:0] rsv,
                                     input logic [7:0] d0, input logic [7:0] d1);
    int w;
    if (r) begin
      model_reset();
      return;
    end
    m_gnt = 2'b00;
    if (m_active) begin
      m_pos++;
      if (m_pos == m_len) begin
        if (m_initq.size() > 0) model_start_init();
        else m_active = 1'b0;
      end
    end else if (req != 2'b00) begin
      w = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
      m_last = w;
      m_gnt = (w == 1) ? 2'b10 : 2'b01;
      m_data = (w == 1) ? d1 : d0;
      m_rs = rsv[w];
      m_pos = 0; m_active = 1'b1;
      m_len = T_SETUP + T_EN + wait_of(m_rs, m_data);
    end
  endfunction

  function automatic logic model_en();
    return m_active && !m_pwr && (m_pos >= T_SETUP) && (m_pos < T_SETUP + T_EN);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, bus.req, bus.req_rs, bus.req_data0, bus.req_data1);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int n = 0;
    bus.req = 2'b00;
    while (bus.busy !== 1'b0 && n < 200) begin tick(); n++; end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", bus.busy, n); end
  endtask

  task automatic do_reset();
    bus.req = 2'b00; rst = 1'b1; tick(); rst = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    int n = 0;
    bit seen = 0;
    logic prev_en = 1'b0;
    int en_bytes[$];
    bus.req = 2'b01; bus.req_rs = 2'b01; bus.req_data0 = 8'h4B; bus.req_data1 = 8'h00;
    rst = 1'b1; tick();
    total++; if (bus.gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt: got %b want 00", bus.gnt); end
    total++; if (bus.en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b want 0", bus.en); end
    total++; if (bus.lcd_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", bus.lcd_data); end
    total++; if (bus.rs !== 1'b0) begin bad++; $display("FAIL rst_rs: got %b want 0", bus.rs); end
    total++; if (bus.wr !== 1'b0) begin bad++; $display("FAIL rst_wr: got %b want 0", bus.wr); end
    total++; if (bus.busy !== RST_BUSY) begin bad++; $display("FAIL rst_busy: got %b want %b", bus.busy, RST_BUSY); end
    rst = 1'b0;
    while (!seen && n < 500) begin
      tick(); n++;
      if (bus.en === 1'b1 && prev_en !== 1'b1) begin
        en_bytes.push_back(int'(bus.lcd_data));
        total++; if (bus.rs !== 1'b0) begin bad++; $display("FAIL init_rs: got %b want 0", bus.rs); end
      end
      prev_en = bus.en;
      if (bus.gnt !== 2'b00) seen = 1;
    end
    total++; if (n != init_total() + 1) begin bad++; $display("FAIL first_gnt_latency: got %0d want %0d", n, init_total() + 1); end
    total++; if (bus.gnt !== 2'b01) begin bad++; $display("FAIL first_gnt: got %b want 01", bus.gnt); end
    total++; if (bus.lcd_data !== 8'h4B) begin bad++; $display("FAIL first_data: got %h want 4b", bus.lcd_data); end
    total++; if (en_bytes.size() != init_list.size()) begin bad++; $display("FAIL init_count: got %0d want %0d", en_bytes.size(), init_list.size()); end
    for (int i = 0; i < init_list.size() && i < en_bytes.size(); i++) begin
      total++; if (en_bytes[i] != init_list[i]) begin bad++; $display("FAIL init_byte%0d: got %h want %h", i, en_bytes[i], init_list[i]); end
    end
    wait_idle();
  endtask

  task automatic test_single();
    bus.req = 2'b01; bus.req_rs = 2'b01; bus.req_data0 = 8'h35;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin bus.req = 2'b00; bus.req_data0 = 8'hCA; bus.req_rs = 2'b00; end
      total++; if (bus.gnt !== ((k == 1) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL single_gnt k=%0d: got %b", k, bus.gnt); end
      total++; if (bus.en !== ((k >= 1 + T_SETUP) && (k < 1 + T_SETUP + T_EN))) begin bad++; $display("FAIL single_en k=%0d: got %b", k, bus.en); end
      total++; if (bus.busy !== (k < 1 + T_SETUP + T_EN + T_CMD)) begin bad++; $display("FAIL single_busy k=%0d: got %b", k, bus.busy); end
      total++; if (bus.lcd_data !== 8'h35 || bus.rs !== 1'b1) begin bad++; $display("FAIL single_hold k=%0d: got %h/%b want 35/1", k, bus.lcd_data, bus.rs); end
    end
    bus.req = 2'b01; tick();
    total++; if (bus.gnt !== 2'b01 || bus.lcd_data !== 8'hCA || bus.rs !== 1'b0) begin bad++; $display("FAIL regrant_data: got %b %h %b want 01 ca 0", bus.gnt, bus.lcd_data, bus.rs); end
    wait_idle();
  endtask

  task automatic test_wait_len();
    int ids[5] = '{1, 1, 0, 1, 0};
    logic rss[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] ds[5] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h00};
    int waits[5] = '{T_CLR, T_CMD, T_CLR, T_CMD, T_CMD};
    for (int t = 0; t < 5; t++) begin
      int busy_n = 0, en_n = 0, n = 0;
      bus.req = (ids[t] == 1) ? 2'b10 : 2'b01;
      bus.req_rs = {rss[t], rss[t]};
      bus.req_data0 = ds[t]; bus.req_data1 = ds[t];
      tick(); bus.req = 2'b00;
      total++; if (bus.gnt !== ((ids[t] == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL wait_gnt%0d: got %b", t, bus.gnt); end
      while (bus.busy === 1'b1 && n < 100) begin
        busy_n++; if (bus.en === 1'b1) en_n++;
        tick(); n++;
      end
      total++; if (busy_n != T_SETUP + T_EN + waits[t]) begin bad++; $display("FAIL wait_len%0d: got %0d want %0d", t, busy_n, T_SETUP + T_EN + waits[t]); end
      total++; if (en_n != T_EN) begin bad++; $display("FAIL en_len%0d: got %0d want %0d", t, en_n, T_EN); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] prev = 2'b00;
    int gcount = 0, n = 0, last_at = -1;
    do_reset();
    bus.req_data0 = 8'h11; bus.req_data1 = 8'h22; bus.req_rs = 2'b11; bus.req = 2'b11;
    while (gcount < 4 && n < 200) begin
      tick(); n++;
      total++; if ((prev & bus.gnt) !== 2'b00) begin bad++; $display("FAIL gnt_repeat: prev %b now %b", prev, bus.gnt); end
      if (bus.gnt !== 2'b00) begin
        total++; if (bus.gnt !== ((gcount % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_order%0d: got %b", gcount, bus.gnt); end
        total++; if (bus.lcd_data !== ((gcount % 2 == 0) ? 8'h11 : 8'h22)) begin bad++; $display("FAIL rr_data%0d: got %h", gcount, bus.lcd_data); end
        if (last_at >= 0) begin
          total++; if (n - last_at != T_SETUP + T_EN + T_CMD + 1) begin bad++; $display("FAIL rr_gap%0d: got %0d want %0d", gcount, n - last_at, T_SETUP + T_EN + T_CMD + 1); end
        end
        last_at = n; gcount++;
      end
      prev = bus.gnt;
    end
    total++; if (gcount != 4) begin bad++; $display("FAIL rr_count: got %0d want 4", gcount); end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bus.req = 2'b01; bus.req_rs = 2'b01; bus.req_data0 = 8'h55;
    while (bus.en !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (bus.en !== 1'b1) begin bad++; $display("FAIL mid_en_rise: got %b want 1", bus.en); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (bus.en !== 1'b0 || bus.gnt !== 2'b00) begin bad++; $display("FAIL mid_abort: en=%b gnt=%b want 0 00", bus.en, bus.gnt); end
    total++; if (bus.lcd_data !== 8'h00 || bus.rs !== 1'b0) begin bad++; $display("FAIL mid_clear: got %h/%b want 00/0", bus.lcd_data, bus.rs); end
    total++; if (bus.busy !== RST_BUSY) begin bad++; $display("FAIL mid_busy: got %b want %b", bus.busy, RST_BUSY); end
    n = 0;
    while (bus.gnt === 2'b00 && n < 500) begin tick(); n++; end
    total++; if (n != init_total() + 1) begin bad++; $display("FAIL mid_regrant_latency: got %0d want %0d", n, init_total() + 1); end
    total++; if (bus.gnt !== 2'b01 || bus.lcd_data !== 8'h55) begin bad++; $display("FAIL mid_regrant: got %b %h want 01 55", bus.gnt, bus.lcd_data); end
    wait_idle();
  endtask

  task automatic test_random();
    logic [1:0] pend = 2'b00;
    for (int c = 0; c < 2000; c++) begin
      rst = (bus.en === 1'b1) && ($urandom_range(0, 49) == 0);
      bus.req = pend;
      tick();
      rst = 1'b0;
      total++; if (bus.gnt !== m_gnt) begin bad++; if (bad < 40) $display("FAIL rnd_gnt c=%0d: got %b want %b", c, bus.gnt, m_gnt); end
      total++; if (bus.busy !== m_active) begin bad++; if (bad < 40) $display("FAIL rnd_busy c=%0d: got %b want %b", c, bus.busy, m_active); end
      total++; if (bus.en !== model_en()) begin bad++; if (bad < 40) $display("FAIL rnd_en c=%0d: got %b want %b", c, bus.en, model_en()); end
      total++; if (bus.lcd_data !== m_data) begin bad++; if (bad < 40) $display("FAIL rnd_data c=%0d: got %h want %h", c, bus.lcd_data, m_data); end
      total++; if (bus.rs !== m_rs || bus.wr !== 1'b0) begin bad++; if (bad < 40) $display("FAIL rnd_rs_wr c=%0d: got %b/%b want %b/0", c, bus.rs, bus.wr, m_rs); end
      for (int i = 0; i < 2; i++) begin
        if (bus.gnt[i] === 1'b1) pend[i] = 1'b0;
        if (!pend[i]) begin
          logic [7:0] d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom);
          if (i == 0) bus.req_data0 = d; else bus.req_data1 = d;
          bus.req_rs[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 2) == 0) pend[i] = 1'b1;
        end
      end
    end
    wait_idle();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
`ifdef LCD_INIT_SEQ_EN
    init_list = {32'h38, 32'h0C, 32'h01, 32'h06};
`endif
    rst = 1'b1;
    bus.req = 2'b00; bus.req_rs = 2'b00; bus.req_data0 = 8'h00; bus.req_data1 = 8'h00;
    model_reset();
    test_reset();
    test_single();
    test_wait_len();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
